// File: rtl/da_wave_pkg.sv
// rtl/da_wave_pkg.sv - shared constants and types for the DAC test-signal generator
package da_wave_pkg;

  localparam logic [1:0] WAVE_SQUARE = 2'd0;
  localparam logic [1:0] WAVE_SAW    = 2'd1;
  localparam logic [1:0] WAVE_TRI    = 2'd2;
  localparam logic [1:0] WAVE_DC     = 2'd3;
  localparam logic [8:0] AMP_UNITY   = 9'd256;
  localparam logic [7:0] MIDSCALE    = 8'd128;

  typedef enum logic {ST_IDLE, ST_RUN} run_state_e;

  function automatic logic [8:0] sat_amp(input logic [8:0] amp);
    return (amp > AMP_UNITY) ? AMP_UNITY : amp;
  endfunction

endpackage

// File: rtl/da_wave_shape.sv
// rtl/da_wave_shape.sv - registered phase-to-raw-sample shape select
module da_wave_shape
  import da_wave_pkg::*;
(
  input  logic       da_clk,
  input  logic       rst_n,
  input  logic [8:0] phase_top,
  input  logic [1:0] wave,
  output logic [7:0] raw
);

  logic [7:0] raw_d;

  // phase_top holds phase[MSB:MSB-8]; bit 8 is the phase MSB.
  always_comb begin
    raw_d = 8'd128;
    case (wave)
      WAVE_SQUARE: raw_d = phase_top[8] ? 8'd0 : 8'd255;
      WAVE_SAW:    raw_d = phase_top[8:1];
      WAVE_TRI:    raw_d = phase_top[8] ? ~phase_top[7:0] : phase_top[7:0];
      default:     raw_d = 8'd128;
    endcase
  end

  always_ff @(posedge da_clk) begin
    if (!rst_n) raw <= 8'd128;
    else        raw <= raw_d;
  end

endmodule

// File: rtl/da_wave_gen.sv
// rtl/da_wave_gen.sv - square/saw/triangle sample source for an 8-bit parallel DAC
module da_wave_gen #(
  parameter int         PHASE_W  = 24,
  parameter logic [7:0] MIDSCALE = da_wave_pkg::MIDSCALE
) (
  input  logic               da_clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [1:0]         cfg_wave,
  input  logic [PHASE_W-1:0] cfg_inc,
  input  logic [8:0]         cfg_amp,
  output logic [7:0]         da_data,
  output logic               sync_pulse
);

  import da_wave_pkg::*;

  run_state_e         state_q, state_d;
  logic [PHASE_W-1:0] phase_q, act_inc, pend_inc;
  logic [1:0]         act_wave, pend_wave;
  logic [8:0]         act_amp, pend_amp, amp_s1;
  logic               pend_q, wrap_q, live_s1, sync_s1;
  logic               advance, wrap, xfer, apply;
  logic [PHASE_W:0]   sum;
  logic [7:0]         raw, scaled;
  logic signed [8:0]  s;
  logic signed [9:0]  amp_sv;
  logic signed [18:0] prod, v_ofs;

  always_comb begin
    state_d = en ? ST_RUN : ST_IDLE;
    advance = (state_q == ST_RUN) && en;
    sum     = {1'b0, phase_q} + {1'b0, act_inc};
    wrap    = advance && sum[PHASE_W];
  end

  assign cfg_ready = !pend_q;
  assign xfer      = cfg_valid && cfg_ready;
  // A transfer and an apply never coincide: one needs pend_q low, the other high.
  assign apply     = pend_q && ((state_q == ST_IDLE) || wrap);

  always_ff @(posedge da_clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      phase_q   <= '0;
      wrap_q    <= 1'b0;
      act_wave  <= WAVE_DC;
      act_inc   <= '0;
      act_amp   <= AMP_UNITY;
      pend_q    <= 1'b0;
      pend_wave <= WAVE_DC;
      pend_inc  <= '0;
      pend_amp  <= AMP_UNITY;
    end else begin
      state_q <= state_d;
      wrap_q  <= wrap;
      if (advance)  phase_q <= sum[PHASE_W-1:0];
      else if (!en) phase_q <= '0;
      if (xfer) begin
        pend_q    <= 1'b1;
        pend_wave <= cfg_wave;
        pend_inc  <= cfg_inc;
        pend_amp  <= sat_amp(cfg_amp);
      end else if (apply) begin
        pend_q   <= 1'b0;
        act_wave <= pend_wave;
        act_inc  <= pend_inc;
        act_amp  <= pend_amp;
      end
    end
  end

  da_wave_shape u_shape (
    .da_clk    (da_clk),
    .rst_n     (rst_n),
    .phase_top (phase_q[PHASE_W-1 -: 9]),
    .wave      (act_wave),
    .raw       (raw)
  );

  // Amplitude, liveness and sync travel alongside the shape register so a
  // config switch lands on one sample boundary.
  always_ff @(posedge da_clk) begin
    if (!rst_n) begin
      amp_s1  <= AMP_UNITY;
      live_s1 <= 1'b0;
      sync_s1 <= 1'b0;
    end else begin
      amp_s1  <= act_amp;
      live_s1 <= advance;
      sync_s1 <= wrap_q && advance;
    end
  end

  always_comb begin
    s      = $signed({1'b0, raw}) - 9'sd128;
    amp_sv = $signed({1'b0, amp_s1});
    prod   = 19'(s) * 19'(amp_sv);
    v_ofs  = (prod >>> 8) + 19'sd128;
    if (v_ofs < 19'sd0)        scaled = 8'd0;
    else if (v_ofs > 19'sd255) scaled = 8'd255;
    else                       scaled = v_ofs[7:0];
  end

  always_ff @(posedge da_clk) begin
    if (!rst_n) begin
      da_data    <= MIDSCALE;
      sync_pulse <= 1'b0;
    end else begin
      da_data    <= live_s1 ? scaled : MIDSCALE;
      sync_pulse <= sync_s1;
    end
  end

endmodule

// File: tb/tb_da_wave_gen.sv
// tb/tb_da_wave_gen.sv - directed self-checking bench for da_wave_gen
module tb_da_wave_gen;

  localparam int PHASE_W = 24;

  logic               da_clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               en = 1'b0;
  logic               cfg_valid = 1'b0;
  logic               cfg_ready;
  logic [1:0]         cfg_wave = 2'd0;
  logic [PHASE_W-1:0] cfg_inc = '0;
  logic [8:0]         cfg_amp = 9'd0;
  logic [7:0]         da_data;
  logic               sync_pulse;

  int errors = 0;
  int checks = 0;

  logic [7:0] cap_d [0:63];
  logic       cap_s [0:63];
  logic       cap_r [0:63];

  always #5 da_clk = ~da_clk;

  da_wave_gen #(.PHASE_W(PHASE_W), .MIDSCALE(8'd128)) dut (
    .da_clk     (da_clk),
    .rst_n      (rst_n),
    .en         (en),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_wave   (cfg_wave),
    .cfg_inc    (cfg_inc),
    .cfg_amp    (cfg_amp),
    .da_data    (da_data),
    .sync_pulse (sync_pulse)
  );

  task automatic send_cfg(input logic [1:0] w, input logic [PHASE_W-1:0] inc, input logic [8:0] amp);
    @(negedge da_clk);
    cfg_wave = w; cfg_inc = inc; cfg_amp = amp; cfg_valid = 1'b1;
    @(posedge da_clk);
    #1 cfg_valid = 1'b0;
  endtask

  task automatic wait_sync(input int budget);
    int n;
    n = 0;
    @(negedge da_clk);
    while (!sync_pulse && n < budget) begin
      @(negedge da_clk);
      n++;
    end
    checks++;
    if (sync_pulse !== 1'b1) begin
      errors++;
      $display("FAIL wait_sync: sync_pulse=%b after %0d cycles, required 1", sync_pulse, budget);
    end
  endtask

  task automatic record(input int k);
    cap_d[k] = da_data; cap_s[k] = sync_pulse; cap_r[k] = cfg_ready;
  endtask

  // Configure in IDLE, enable, then capture n samples starting at the first sync.
  task automatic run_capture(input logic [1:0] w, input logic [PHASE_W-1:0] inc,
                             input logic [8:0] amp, input int n);
    en = 1'b0;
    repeat (2) @(negedge da_clk);
    send_cfg(w, inc, amp);
    repeat (2) @(negedge da_clk);
    en = 1'b1;
    wait_sync(80);
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge da_clk);
      record(k);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; en = 1'b0;
    repeat (3) @(negedge da_clk);
    checks++; if (da_data !== 8'd128) begin errors++; $display("FAIL reset da_data=%0d required 128", da_data); end
    checks++; if (sync_pulse !== 1'b0) begin errors++; $display("FAIL reset sync_pulse=%b required 0", sync_pulse); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset cfg_ready=%b required 1", cfg_ready); end
    rst_n = 1'b1;
    @(negedge da_clk);
  endtask

  task automatic test_square;
    logic [7:0] exp_d;
    en = 1'b0;
    send_cfg(2'd0, 24'h100000, 9'd256);
    @(negedge da_clk);
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL idle_hs_low cfg_ready=%b required 0", cfg_ready); end
    @(negedge da_clk);
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL idle_hs_high cfg_ready=%b required 1", cfg_ready); end
    en = 1'b1;
    wait_sync(40);
    for (int k = 0; k < 32; k++) begin
      if (k > 0) @(negedge da_clk);
      exp_d = ((k % 16) < 8) ? 8'd255 : 8'd0;
      checks++; if (da_data !== exp_d) begin errors++; $display("FAIL square k=%0d da_data=%0d required %0d", k, da_data, exp_d); end
      checks++; if (sync_pulse !== ((k % 16) == 0)) begin errors++; $display("FAIL square_sync k=%0d sync_pulse=%b", k, sync_pulse); end
    end
  endtask

  task automatic test_saw;
    run_capture(2'd1, 24'h100000, 9'd256, 16);
    for (int k = 0; k < 16; k++) begin
      checks++; if (cap_d[k] !== 8'(16 * k)) begin errors++; $display("FAIL saw_full k=%0d da_data=%0d required %0d", k, cap_d[k], 16 * k); end
    end
    run_capture(2'd1, 24'h100000, 9'd128, 16);
    for (int k = 0; k < 16; k++) begin
      checks++; if (cap_d[k] !== 8'(64 + 8 * k)) begin errors++; $display("FAIL saw_half k=%0d da_data=%0d required %0d", k, cap_d[k], 64 + 8 * k); end
    end
  endtask

  task automatic test_amp_sat;
    run_capture(2'd1, 24'h100000, 9'd300, 16);
    for (int k = 0; k < 16; k++) begin
      checks++; if (cap_d[k] !== 8'(16 * k)) begin errors++; $display("FAIL amp_sat k=%0d da_data=%0d required %0d", k, cap_d[k], 16 * k); end
    end
  endtask

  task automatic test_triangle;
    logic [7:0] exp_d;
    run_capture(2'd2, 24'h080000, 9'd256, 32);
    for (int k = 0; k < 32; k++) begin
      exp_d = (k < 16) ? 8'(16 * k) : 8'(255 - 16 * (k - 16));
      checks++; if (cap_d[k] !== exp_d) begin errors++; $display("FAIL tri k=%0d da_data=%0d required %0d", k, cap_d[k], exp_d); end
      checks++; if (cap_s[k] !== (k == 0)) begin errors++; $display("FAIL tri_sync k=%0d sync_pulse=%b", k, cap_s[k]); end
    end
  endtask

  // Saw offered mid-period, then square offered in the wrap cycle itself.
  task automatic test_run_update;
    logic [7:0] exp_d;
    logic       exp_r;
    run_capture(2'd0, 24'h100000, 9'd256, 1);
    for (int k = 0; k < 64; k++) begin
      if (k > 0) begin
        @(negedge da_clk);
        record(k);
      end
      if (k == 0) begin
        cfg_wave = 2'd1; cfg_inc = 24'h100000; cfg_amp = 9'd256; cfg_valid = 1'b1;
      end else if (k == 29) begin
        cfg_wave = 2'd0; cfg_inc = 24'h100000; cfg_amp = 9'd256; cfg_valid = 1'b1;
      end else begin
        cfg_valid = 1'b0;
      end
    end
    cfg_valid = 1'b0;
    for (int k = 0; k < 64; k++) begin
      if (k < 16 || k >= 48) exp_d = ((k % 16) < 8) ? 8'd255 : 8'd0;
      else                   exp_d = 8'(16 * (k % 16));
      exp_r = !((k >= 1 && k <= 13) || (k >= 30 && k <= 45));
      checks++; if (cap_d[k] !== exp_d) begin errors++; $display("FAIL run_update k=%0d da_data=%0d required %0d", k, cap_d[k], exp_d); end
      checks++; if (cap_r[k] !== exp_r) begin errors++; $display("FAIL run_ready k=%0d cfg_ready=%b required %b", k, cap_r[k], exp_r); end
      checks++; if (cap_s[k] !== ((k % 16) == 0)) begin errors++; $display("FAIL run_sync k=%0d sync_pulse=%b", k, cap_s[k]); end
    end
  endtask

  task automatic test_en_drop;
    run_capture(2'd0, 24'h100000, 9'd256, 1);
    en = 1'b0;
    repeat (2) @(negedge da_clk);
    checks++; if (da_data !== 8'd128) begin errors++; $display("FAIL en_drop da_data=%0d required 128", da_data); end
    checks++; if (sync_pulse !== 1'b0) begin errors++; $display("FAIL en_drop sync_pulse=%b required 0", sync_pulse); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL en_drop cfg_ready=%b required 1", cfg_ready); end
  endtask

  task automatic test_inc_zero;
    en = 1'b0;
    repeat (2) @(negedge da_clk);
    send_cfg(2'd0, 24'h000000, 9'd256);
    repeat (2) @(negedge da_clk);
    en = 1'b1;
    repeat (4) @(negedge da_clk);
    for (int k = 0; k < 20; k++) begin
      @(negedge da_clk);
      checks++; if (da_data !== 8'd255 || sync_pulse !== 1'b0) begin
        errors++; $display("FAIL inc_zero k=%0d da_data=%0d sync_pulse=%b required 255/0", k, da_data, sync_pulse);
      end
    end
  endtask

  task automatic test_reset_mid;
    run_capture(2'd0, 24'h100000, 9'd256, 1);
    cfg_wave = 2'd1; cfg_inc = 24'h100000; cfg_amp = 9'd256; cfg_valid = 1'b1;
    @(negedge da_clk);
    cfg_valid = 1'b0;
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL pend_before_reset cfg_ready=%b required 0", cfg_ready); end
    rst_n = 1'b0; en = 1'b0;
    @(negedge da_clk);
    checks++; if (da_data !== 8'd128) begin errors++; $display("FAIL reset_mid da_data=%0d required 128", da_data); end
    checks++; if (sync_pulse !== 1'b0) begin errors++; $display("FAIL reset_mid sync_pulse=%b required 0", sync_pulse); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_mid cfg_ready=%b required 1", cfg_ready); end
    rst_n = 1'b1; en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge da_clk);
      checks++; if (da_data !== 8'd128 || sync_pulse !== 1'b0) begin
        errors++; $display("FAIL discard_pending k=%0d da_data=%0d sync_pulse=%b required 128/0", k, da_data, sync_pulse);
      end
    end
  endtask

  initial begin
    test_reset;
    test_square;
    test_saw;
    test_amp_sat;
    test_triangle;
    test_run_update;
    test_en_drop;
    test_inc_zero;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
